// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and constants for the sram_array storage block.
//   state_t  : controller state (ST_INIT = clear sweep running, ST_IDLE = serving)
//   RW_WRITE : value of rw that requests a write
//   RW_READ  : value of rw that requests a read
// -----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/sram_word.sv
// -----------------------------------------------------------------------------
// sram_word
// One WIDTH-bit storage row of the array. The row has no reset; the parent
// zeroes it through the clear sweep when required.
// Ports:
//   clk    in   1      rising-edge clock
//   we     in   1      write enable for this row
//   wdata  in   WIDTH  data written when we=1
//   rdata  out  WIDTH  current row contents
// -----------------------------------------------------------------------------
module sram_word
    import sram_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r;

    // Row storage: load on write enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r <= wdata;
        end else begin
            mem_r <= mem_r;
        end
    end

    assign rdata = mem_r;

endmodule

// File: rtl/sram_array.sv
// -----------------------------------------------------------------------------
// sram_array
// Single-port synchronous storage of DEPTH words x WIDTH bits with a
// ready/valid request port, registered read data, address range checking and
// a hardware clear sweep (after reset when INIT_ON_RESET=1, or on clr).
// Ports:
//   clk        in   1      clock, all state changes on the rising edge
//   rst        in   1      synchronous active-high reset
//   clr        in   1      pulse: zero every word via the clear sweep
//   sel        in   1      request valid, accepted only while ready=1
//   rw         in   1      1 = write, 0 = read
//   addr       in   AW     word address
//   data       in   WIDTH  write data
//   ready      out  1      request can be accepted this cycle
//   out        out  WIDTH  registered read data (holds when out_valid=0)
//   out_valid  out  1      pulse: out carries the read accepted last cycle
//   err        out  1      pulse: request accepted last cycle was out of range
// -----------------------------------------------------------------------------
module sram_array
    import sram_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter bit INIT_ON_RESET = 1'b1,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sel,
    input  logic             rw,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             err
);

    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] CNT_ONE  = AW'(1'b1);
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    state_t           state_r;
    logic [AW-1:0]    cnt_r;
    logic             ready_r;
    logic [WIDTH-1:0] out_r;
    logic             out_valid_r;
    logic             err_r;

    logic             accept_s;
    logic             in_range_s;
    logic             is_write_s;
    logic             sweeping_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] rd_word_s;
    logic [WIDTH-1:0] rdata_s [DEPTH];

    // ready_r is only ever 1 in ST_IDLE, so it also gates out requests during
    // the sweep; clr takes priority over a request in the same cycle.
    assign accept_s   = sel & ready_r & ~clr;
    assign in_range_s = ({1'b0, addr} < DEPTH_W);
    assign is_write_s = (rw == RW_WRITE);
    assign sweeping_s = (state_r == ST_INIT);
    assign wdata_s    = sweeping_s ? {WIDTH{1'b0}} : data;

    // Storage rows: written by the sweep counter in INIT, by an accepted
    // in-range write otherwise. Out-of-range writes touch no row.
    for (genvar i = 0; i < DEPTH; i++) begin : g_row
        localparam logic [AW-1:0] ROW_IDX = AW'(i);
        logic we_s;

        assign we_s = sweeping_s
                    ? (cnt_r == ROW_IDX)
                    : (accept_s & is_write_s & in_range_s & (addr == ROW_IDX));

        sram_word #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk   (clk),
            .we    (we_s),
            .wdata (wdata_s),
            .rdata (rdata_s[i])
        );
    end

    // Read mux: an out-of-range address yields zero rather than an alias.
    always_comb begin
        rd_word_s = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (in_range_s && (addr == AW'(i))) begin
                rd_word_s = rdata_s[i];
            end else begin
                rd_word_s = rd_word_s;
            end
        end
    end

    // Controller FSM with sweep counter and registered handshake/read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
            cnt_r       <= {AW{1'b0}};
            ready_r     <= ~INIT_ON_RESET;
            out_r       <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    if (clr) begin
                        cnt_r <= {AW{1'b0}};
                    end else if (cnt_r == CNT_LAST) begin
                        // This edge clears the last word; serve from next cycle.
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                        cnt_r   <= {AW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        state_r <= ST_INIT;
                        ready_r <= 1'b0;
                        cnt_r   <= {AW{1'b0}};
                    end else if (accept_s) begin
                        err_r <= ~in_range_s;
                        if (!is_write_s) begin
                            out_r       <= rd_word_s;
                            out_valid_r <= 1'b1;
                        end else begin
                            out_r <= out_r;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                    ready_r <= 1'b0;
                    cnt_r   <= {AW{1'b0}};
                end
            endcase
        end
    end

    assign ready     = ready_r;
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign err       = err_r;

endmodule

// File: tb/tb_sram_array.sv
// -----------------------------------------------------------------------------
// tb_sram_array
// Directed bench for sram_array. Three instances share one request bus:
//   a : WIDTH=8, DEPTH=16, INIT_ON_RESET=1
//   b : WIDTH=8, DEPTH=12, INIT_ON_RESET=1  (out-of-range addresses exist)
//   c : WIDTH=8, DEPTH=12, INIT_ON_RESET=0
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_sram_array;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       sel;
    logic       rw;
    logic [3:0] addr;
    logic [7:0] data;

    logic       a_ready, b_ready, c_ready;
    logic [7:0] a_out, b_out, c_out;
    logic       a_ov, b_ov, c_ov;
    logic       a_err, b_err, c_err;

    int total = 0;
    int bad   = 0;

    sram_array #(.WIDTH(8), .DEPTH(16), .INIT_ON_RESET(1'b1)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .sel(sel), .rw(rw), .addr(addr), .data(data),
        .ready(a_ready), .out(a_out), .out_valid(a_ov), .err(a_err)
    );

    sram_array #(.WIDTH(8), .DEPTH(12), .INIT_ON_RESET(1'b1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .sel(sel), .rw(rw), .addr(addr), .data(data),
        .ready(b_ready), .out(b_out), .out_valid(b_ov), .err(b_err)
    );

    sram_array #(.WIDTH(8), .DEPTH(12), .INIT_ON_RESET(1'b0)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .sel(sel), .rw(rw), .addr(addr), .data(data),
        .ready(c_ready), .out(c_out), .out_valid(c_ov), .err(c_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        sel = 1'b1; rw = 1'b1; addr = a; data = d;
        tick();
        sel = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a);
        sel = 1'b1; rw = 1'b0; addr = a;
        tick();
        sel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; sel = 1'b0; rw = 1'b0; addr = 4'd0; data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", a_ready); end
        total++; if (a_out !== 8'h00) begin bad++; $display("FAIL reset_out got=%h want=00", a_out); end
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", a_ov); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", a_err); end
        total++; if (c_ready !== 1'b1) begin bad++; $display("FAIL reset_noinit_ready got=%b want=1", c_ready); end
    endtask

    task automatic test_init_sweep();
        for (int i = 1; i <= 16; i++) begin
            total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL sweep_ready cycle=%0d got=%b want=0", i, a_ready); end
            tick();
        end
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL sweep_done_ready got=%b want=1", a_ready); end
        sel = 1'b1; rw = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            tick();
            total++;
            if (a_ov !== 1'b1 || a_out !== 8'h00) begin
                bad++; $display("FAIL sweep_zero addr=%0d got ov=%b out=%h want ov=1 out=00", i, a_ov, a_out);
            end
        end
        sel = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        do_write(4'd3, 8'hA5);
        total++; if (a_ov !== 1'b0 || a_err !== 1'b0) begin bad++; $display("FAIL write_no_pulse got ov=%b err=%b want 0 0", a_ov, a_err); end
        do_read(4'd3);
        total++;
        if (a_out !== 8'hA5 || a_ov !== 1'b1 || a_err !== 1'b0) begin
            bad++; $display("FAIL write_read got out=%h ov=%b err=%b want A5 1 0", a_out, a_ov, a_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_v;
        for (int i = 0; i < 16; i++) do_write(4'(i), 8'(i) ^ 8'hFF);
        sel = 1'b1; rw = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            tick();
            exp_v = 8'(i) ^ 8'hFF;
            total++;
            if (a_ov !== 1'b1 || a_out !== exp_v) begin
                bad++; $display("FAIL b2b addr=%0d got ov=%b out=%h want ov=1 out=%h", i, a_ov, a_out, exp_v);
            end
        end
        sel = 1'b0;
        tick();
        total++; if (a_ov !== 1'b0 || a_out !== 8'hF0) begin bad++; $display("FAIL b2b_hold got ov=%b out=%h want 0 F0", a_ov, a_out); end
    endtask

    task automatic test_out_of_range();
        do_write(4'd1, 8'h11);
        do_write(4'd13, 8'h55);
        total++; if (b_err !== 1'b1 || b_ov !== 1'b0) begin bad++; $display("FAIL oor_write got err=%b ov=%b want 1 0", b_err, b_ov); end
        do_read(4'd13);
        total++;
        if (b_out !== 8'h00 || b_ov !== 1'b1 || b_err !== 1'b1) begin
            bad++; $display("FAIL oor_read got out=%h ov=%b err=%b want 00 1 1", b_out, b_ov, b_err);
        end
        do_read(4'd1);
        total++;
        if (b_out !== 8'h11 || b_ov !== 1'b1 || b_err !== 1'b0) begin
            bad++; $display("FAIL oor_alias got out=%h ov=%b err=%b want 11 1 0", b_out, b_ov, b_err);
        end
        total++; if (a_out !== 8'h11) begin bad++; $display("FAIL oor_a_word1 got=%h want=11", a_out); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 16; i++) do_write(4'(i), 8'h3C);
        clr = 1'b1; sel = 1'b1; rw = 1'b1; addr = 4'd2; data = 8'h77;
        tick();
        clr = 1'b0; sel = 1'b0;
        total++; if (a_ov !== 1'b0 || a_err !== 1'b0) begin bad++; $display("FAIL clr_drop got ov=%b err=%b want 0 0", a_ov, a_err); end
        for (int i = 1; i <= 16; i++) begin
            total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL clr_ready cycle=%0d got=%b want=0", i, a_ready); end
            tick();
        end
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL clr_done_ready got=%b want=1", a_ready); end
        total++; if (a_out !== 8'h11) begin bad++; $display("FAIL clr_out_hold got=%h want=11", a_out); end
        sel = 1'b1; rw = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            tick();
            total++;
            if (a_ov !== 1'b1 || a_out !== 8'h00) begin
                bad++; $display("FAIL clr_zero addr=%0d got ov=%b out=%h want ov=1 out=00", i, a_ov, a_out);
            end
        end
        sel = 1'b0;
        // Reset in cycle 5 of a fresh sweep restarts it from word 0.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (a_out !== 8'h00) begin bad++; $display("FAIL rst_mid_out got=%h want=00", a_out); end
        total++; if (c_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_noinit_ready got=%b want=1", c_ready); end
        for (int i = 1; i <= 16; i++) begin
            total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready cycle=%0d got=%b want=0", i, a_ready); end
            tick();
        end
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_done_ready got=%b want=1", a_ready); end
    endtask

    task automatic test_init_no_reset();
        // A read coinciding with clr is dropped.
        clr = 1'b1; sel = 1'b1; rw = 1'b0; addr = 4'd5;
        tick();
        clr = 1'b0;
        total++; if (c_ov !== 1'b0) begin bad++; $display("FAIL clr_read_drop got ov=%b want 0", c_ov); end
        for (int i = 0; i < 12; i++) begin
            total++; if (c_ready !== 1'b0) begin bad++; $display("FAIL c_sweep_ready cycle=%0d got=%b want=0", i + 1, c_ready); end
            sel = 1'b1;
            if (i < 8) begin
                rw = 1'b0; addr = 4'd13;
            end else begin
                rw = 1'b1; addr = 4'd3; data = 8'hEE;
            end
            tick();
            total++;
            if (c_ov !== 1'b0 || c_err !== 1'b0) begin
                bad++; $display("FAIL c_sweep_ignore cycle=%0d got ov=%b err=%b want 0 0", i + 1, c_ov, c_err);
            end
        end
        sel = 1'b0;
        total++; if (c_ready !== 1'b1) begin bad++; $display("FAIL c_sweep_done_ready got=%b want=1", c_ready); end
        do_read(4'd3);
        total++;
        if (c_out !== 8'h00 || c_ov !== 1'b1) begin
            bad++; $display("FAIL c_sweep_nowrite got out=%h ov=%b want 00 1", c_out, c_ov);
        end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_clear();
        test_init_no_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
